pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline / reorder-buffer control.
//
// Tracks the ROB head and tail pointers and the occupancy count. It hands out
// ROB tags to the decoder, retires entries on commit, and stalls IF/ID when the
// ROB or the reservation station is full. A mispredicted branch that retires
// empties the ROB and enters a FLUSH state. FLUSH lasts FLUSH_CYCLES enabled
// cycles, and the RAT is cleared in the first of them.
//
// Parameters
//   ROB_DEPTH    : number of ROB entries; a power of two, at least 4.
//   FLUSH_CYCLES : length of the FLUSH state in enabled cycles; at least 1.
//
// Ports (AW = $clog2(ROB_DEPTH))
//   clk, rst_n    : clock; asynchronous active-low reset
//   cpu_en        : global enable; all state holds while low
//   dec_valid     : decoder requests a ROB entry
//   rs_full       : reservation station cannot accept
//   commit_valid  : ROB head retires this cycle
//   mispredict    : retiring entry is a mispredicted branch
//   alloc_rob     : [AW]   tag for the current decode (tail pointer)
//   alloc_fire    : allocation accepted this cycle
//   rob_head      : [AW]   oldest entry
//   rob_count     : [AW+1] occupied entries
//   rob_full      : rob_count == ROB_DEPTH
//   if_stall/id_stall : hold IF/ID pipeline registers
//   if_flush/id_flush : squash IF/ID pipeline registers
//   rat_clear     : one-cycle pulse that invalidates all RAT mappings
//   ctrl_busy     : FSM is not in RUN
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int ROB_DEPTH    = 8,
   parameter int FLUSH_CYCLES = 2,
   localparam int AW = $clog2(ROB_DEPTH),
   localparam int CW = AW + 1,
   localparam int FW = $clog2(FLUSH_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_en,
   input  logic          dec_valid,
   input  logic          rs_full,
   input  logic          commit_valid,
   input  logic          mispredict,
   output logic [AW-1:0] alloc_rob,
   output logic          alloc_fire,
   output logic [AW-1:0] rob_head,
   output logic [CW-1:0] rob_count,
   output logic          rob_full,
   output logic          if_stall,
   output logic          id_stall,
   output logic          if_flush,
   output logic          id_flush,
   output logic          rat_clear,
   output logic          ctrl_busy
);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] tail_q,  tail_d;
   logic [AW-1:0] head_q,  head_d;
   logic [CW-1:0] count_q, count_d;
   logic [FW-1:0] fcnt_q,  fcnt_d;
   logic          rat_q,   rat_d;

   logic in_run;
   logic full;
   logic commit_ok;
   logic flush_ok;

   assign in_run    = (state_q == RUN);
   assign full      = (count_q == CW'(ROB_DEPTH));
   // A retiring mispredict blocks allocation even if that commit is ignored.
   assign alloc_fire = in_run && cpu_en && dec_valid && !full && !rs_full
                       && !(commit_valid && mispredict);
   assign commit_ok = commit_valid && (count_q != '0) && in_run && cpu_en;
   assign flush_ok  = commit_ok && mispredict;

   // Next-state logic.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves
      // it unassigned and no latch is inferred.
      state_d = state_q;
      tail_d  = tail_q;
      head_d  = head_q;
      count_d = count_q;
      fcnt_d  = fcnt_q;
      rat_d   = 1'b0;      // rat_clear is only ever a single-cycle pulse

      if (state_q == RUN) begin
         if (flush_ok) begin
            // The mispredicted branch retires. Every younger entry is
            // discarded, so the ROB restarts empty just past the branch.
            head_d  = head_q + AW'(1);
            tail_d  = head_q + AW'(1);
            count_d = '0;
            state_d = FLUSH;
            fcnt_d  = FW'(FLUSH_CYCLES - 1);
            rat_d   = 1'b1;
         end else begin
            if (alloc_fire) tail_d = tail_q + AW'(1);
            if (commit_ok)  head_d = head_q + AW'(1);
            count_d = count_q + CW'(alloc_fire) - CW'(commit_ok);
         end
      end else if (cpu_en) begin
         if (fcnt_q == '0) state_d = RUN;
         else              fcnt_d  = fcnt_q - FW'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         tail_q  <= '0;
         head_q  <= '0;
         count_q <= '0;
         fcnt_q  <= '0;
         rat_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments. Every register
         // then samples pre-edge values, and no update order is implied.
         state_q <= state_d;
         tail_q  <= tail_d;
         head_q  <= head_d;
         count_q <= count_d;
         fcnt_q  <= fcnt_d;
         rat_q   <= rat_d;
      end
   end

   // Outputs.
   assign alloc_rob = tail_q;
   assign rob_head  = head_q;
   assign rob_count = count_q;
   assign rob_full  = full;
   assign if_stall  = in_run && dec_valid && (full || rs_full);
   assign id_stall  = if_stall;
   assign if_flush  = !in_run;
   assign id_flush  = !in_run;
   assign ctrl_busy = !in_run;
   assign rat_clear = rat_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// Each stimulus cycle derives the expected outputs from an integer-level ROB
// model and pushes them into a queue. A monitor process pops one entry on
// every falling edge and compares it with the DUT outputs. Directed sequences
// exercise fill, simultaneous alloc/commit, mispredict flush, enable, reset
// and the empty/rs_full corner cases. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int D  = 8;
   localparam int FC = 2;
   localparam int AW = $clog2(D);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_en = 1'b0, dec_valid = 1'b0, rs_full = 1'b0;
   logic          commit_valid = 1'b0, mispredict = 1'b0;
   logic [AW-1:0] alloc_rob, rob_head;
   logic [AW:0]   rob_count;
   logic          alloc_fire, rob_full, if_stall, id_stall;
   logic          if_flush, id_flush, rat_clear, ctrl_busy;

   pipe_ctrl #(.ROB_DEPTH(D), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .dec_valid(dec_valid),
      .rs_full(rs_full), .commit_valid(commit_valid), .mispredict(mispredict),
      .alloc_rob(alloc_rob), .alloc_fire(alloc_fire), .rob_head(rob_head),
      .rob_count(rob_count), .rob_full(rob_full), .if_stall(if_stall),
      .id_stall(id_stall), .if_flush(if_flush), .id_flush(id_flush),
      .rat_clear(rat_clear), .ctrl_busy(ctrl_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (ROB as integers) ----------------
   int m_head, m_tail, m_count, m_fleft;
   bit m_flushing, m_first;
   bit s_en, s_dv, s_rf, s_cv, s_mp;

   typedef struct {
      int alloc_rob, alloc_fire, rob_head, rob_count, rob_full;
      int stall, flush, rat_clear, busy;
   } exp_t;

   exp_t exp_q[$];

   function automatic void model_reset();
      m_head = 0; m_tail = 0; m_count = 0; m_fleft = 0;
      m_flushing = 0; m_first = 0;
   endfunction

   function automatic bit m_fire();
      return !m_flushing && s_en && s_dv && (m_count != D) && !s_rf
             && !(s_cv && s_mp);
   endfunction

   function automatic bit m_commit();
      return s_cv && (m_count != 0) && !m_flushing && s_en;
   endfunction

   // Apply inputs for the coming edge and queue the outputs expected this cycle.
   task automatic drive(input bit en, dv, rf, cv, mp);
      exp_t e;
      cpu_en = en; dec_valid = dv; rs_full = rf; commit_valid = cv; mispredict = mp;
      s_en = en; s_dv = dv; s_rf = rf; s_cv = cv; s_mp = mp;
      e.alloc_rob  = m_tail;
      e.alloc_fire = m_fire();
      e.rob_head   = m_head;
      e.rob_count  = m_count;
      e.rob_full   = (m_count == D);
      e.stall      = !m_flushing && dv && ((m_count == D) || rf);
      e.flush      = m_flushing;
      e.rat_clear  = m_first;
      e.busy       = m_flushing;
      exp_q.push_back(e);
   endtask

   // Advance one edge and update the model with the inputs that were applied.
   task automatic tick();
      bit fire, cmt;
      fire = m_fire();
      cmt  = m_commit();
      @(posedge clk);
      m_first = 0;
      if (cmt && s_mp) begin
         m_head = (m_head + 1) % D;
         m_tail = m_head;
         m_count = 0;
         m_flushing = 1;
         m_fleft = FC;          // enabled cycles still to spend in FLUSH
         m_first = 1;
      end else if (!m_flushing) begin
         if (fire) m_tail = (m_tail + 1) % D;
         if (cmt)  m_head = (m_head + 1) % D;
         m_count = m_count + int'(fire) - int'(cmt);
      end else if (s_en) begin
         m_fleft--;
         if (m_fleft == 0) m_flushing = 0;
      end
      #1;
   endtask

   task automatic cyc(input bit en, dv, rf, cv, mp);
      drive(en, dv, rf, cv, mp);
      tick();
   endtask

   // Assert reset mid-cycle; every output must drop to 0 asynchronously.
   task automatic apply_reset();
      cpu_en = 0; dec_valid = 0; rs_full = 0; commit_valid = 0; mispredict = 0;
      rst_n = 1'b0;
      #1;
      check("rst alloc_rob", alloc_rob, 0);
      check("rst alloc_fire", alloc_fire, 0);
      check("rst rob_head", rob_head, 0);
      check("rst rob_count", rob_count, 0);
      check("rst rob_full", rob_full, 0);
      check("rst stalls", {if_stall, id_stall}, 0);
      check("rst flushes", {if_flush, id_flush}, 0);
      check("rst rat_clear", rat_clear, 0);
      check("rst ctrl_busy", ctrl_busy, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb alloc_rob", alloc_rob, e.alloc_rob);
            check("sb alloc_fire", alloc_fire, e.alloc_fire);
            check("sb rob_head", rob_head, e.rob_head);
            check("sb rob_count", rob_count, e.rob_count);
            check("sb rob_full", rob_full, e.rob_full);
            check("sb if_stall", if_stall, e.stall);
            check("sb id_stall", id_stall, e.stall);
            check("sb if_flush", if_flush, e.flush);
            check("sb id_flush", id_flush, e.flush);
            check("sb rat_clear", rat_clear, e.rat_clear);
            check("sb ctrl_busy", ctrl_busy, e.busy);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      #2;
      apply_reset();

      // Fill: 9 cycles of dec_valid; the ninth stalls with no allocation.
      for (int i = 0; i < 9; i++) begin
         drive(1, 1, 0, 0, 0);
         #1;
         if (i < 8) check("fill alloc_rob", alloc_rob, i);
         else begin
            check("fill9 id_stall", id_stall, 1);
            check("fill9 alloc_fire", alloc_fire, 0);
         end
         tick();
      end
      check("fill rob_count", rob_count, 8);
      check("fill rob_full", rob_full, 1);

      // Simultaneous alloc+commit: first while full, then at count 7.
      drive(1, 1, 0, 1, 0);
      #1 check("simul full alloc_fire", alloc_fire, 0);
      tick();
      check("simul head", rob_head, 1);
      check("simul count7", rob_count, 7);
      cyc(1, 1, 0, 1, 0);
      check("simul count stays", rob_count, 7);
      check("simul tail wrap", alloc_rob, 1);

      // Mispredict: reach head=3, count=5.
      apply_reset();
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
      check("mp pre head", rob_head, 3);
      check("mp pre count", rob_count, 5);
      cyc(1, 0, 0, 1, 1);
      check("mp head", rob_head, 4);
      check("mp tail", alloc_rob, 4);
      check("mp count", rob_count, 0);
      check("mp rat_clear", rat_clear, 1);
      check("mp flushes", {if_flush, id_flush}, 2'b11);
      cyc(1, 1, 0, 1, 0);
      check("mp2 rat_clear", rat_clear, 0);
      check("mp2 flushes", {if_flush, id_flush}, 2'b11);
      cyc(1, 0, 0, 0, 0);
      check("mp run flushes", {if_flush, id_flush}, 0);
      check("mp run alloc_rob", alloc_rob, 4);

      // Enable low freezes everything.
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 1, 0);
         #1 check("en0 alloc_fire", alloc_fire, 0);
         tick();
      end
      check("en0 count", rob_count, 2);
      check("en0 head", rob_head, 4);
      check("en0 tail", alloc_rob, 6);

      // Empty commit, then rs_full stall.
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      check("empty commit head", rob_head, 6);
      check("empty commit count", rob_count, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      drive(1, 1, 1, 0, 0);
      #1;
      check("rsfull id_stall", id_stall, 1);
      check("rsfull alloc_fire", alloc_fire, 0);
      tick();

      // Reset during the second FLUSH cycle.
      cyc(1, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 0);
      check("rst pre busy", ctrl_busy, 1);
      apply_reset();
      cyc(1, 1, 0, 0, 0);   // allocation on the first edge after reset
      check("post rst count", rob_count, 1);
      check("post rst no flush", {if_flush, id_flush, rat_clear, ctrl_busy}, 0);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15) == 0);
      end

      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      check("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
